l1_mem_arbiter: RTL
===================

// Module: l1_mem_arbiter
// PURPOSE
//  Arbitrates line-sized misses from the L1 instruction and L1 data caches onto the single L2 cache port.
//  Sits directly downstream of both L1 caches and upstream of l2_cache.
//  Serves one transaction at a time, with registered L2-side request outputs and a latched address/data snapshot.
//  Fixed-priority or round-robin selection when both L1s request in the same cycle.
// PARAMETERS
//  ADDR_W       16   address width, both sides
//  LINE_W       128  cache line width (rdata/wdata)
//  ROUND_ROBIN  0    0: D-cache always wins ties; 1: tie goes to the port not served last
// PORTS
//  clk           in   1       system clock, all state on rising edge
//  rst           in   1       synchronous reset, active-high
//  l1_i_read     in   1       I-cache line read request (level, held until l1_i_resp)
//  l1_i_address  in   ADDR_W  I-cache line address
//  l1_i_rdata    out  LINE_W  line returned to I-cache
//  l1_i_resp     out  1       one-cycle completion pulse to I-cache
//  l1_d_read     in   1       D-cache line read request (level)
//  l1_d_write    in   1       D-cache line writeback request (level)
//  l1_d_address  in   ADDR_W  D-cache line address
//  l1_d_wdata    in   LINE_W  D-cache writeback line
//  l1_d_rdata    out  LINE_W  line returned to D-cache
//  l1_d_resp     out  1       one-cycle completion pulse to D-cache
//  l2_read       out  1       registered read request to L2
//  l2_write      out  1       registered write request to L2
//  l2_address    out  ADDR_W  registered (latched) address to L2
//  l2_wdata      out  LINE_W  registered (latched) write line to L2
//  l2_resp       in   1       L2 completion pulse
//  l2_rdata      in   LINE_W  L2 read line, valid while l2_resp=1
// BEHAVIOUR
//  Reset: state=IDLE; l2_read=l2_write=0, l2_address=0, l2_wdata=0, l1_i_resp=l1_d_resp=0, last_served=I.
//  The reset effect is visible in the cycle after rst is sampled high.
//  FSM states: IDLE, SERVE_I, SERVE_D, RECOVER.
//  IDLE:
//   - req_i = l1_i_read; req_d = l1_d_read|l1_d_write.
//   - Only one request: grant it.
//   - Both requests: ROUND_ROBIN=0 grants D; ROUND_ROBIN=1 grants the port != last_served.
//   - On grant: latch address (and l1_d_wdata for D) into l2_address/l2_wdata.
//   - On grant: set l2_read, or l2_write (D write), on the same edge.
//   - Request sampled high in cycle N => l2_read/l2_write high in cycle N+1.
//  D read and write both high: treated as write (writeback before refill); the read is re-arbitrated afterwards.
//  SERVE_I / SERVE_D:
//   - l2_* outputs held stable; later changes on L1 inputs are ignored.
//   - l1_x_resp = l2_resp & (state==SERVE_X), combinational.
//   - l1_x_rdata = l2_rdata, pass-through to both ports; meaningful only with resp.
//   - On l2_resp: clear l2_read/l2_write, update last_served, go to RECOVER.
//   - The non-served L1 sees resp=0 throughout.
//  RECOVER:
//   - Exactly one cycle with l2_read=l2_write=0 and both resps=0, so the served L1 drops its request.
//   - Then return to IDLE.
//   - Back-to-back: a pending other-port request is granted in IDLE, so it reaches L2 at RECOVER+2.
//  Fairness: with ROUND_ROBIN=1 and both ports continuously requesting, grants strictly alternate.
//  l2_resp while in IDLE or RECOVER is ignored; no L1 resp is produced.
//  rst mid-transaction:
//   - The transaction is abandoned; no L1 resp is generated.
//   - The FSM returns to IDLE; requests still asserted after reset are re-arbitrated normally.
//  No latency limit: arbiter waits indefinitely for l2_resp.
// TESTING
//  T1:
//   - Stimulus: I read 0x1230 alone; L2 resp 3 cycles after l2_read with rdata=128'hA5..A5.
//   - Required response: l2_read rises at N+1 with addr 0x1230; l1_i_resp is a 1-cycle pulse with rdata A5..A5; l1_d_resp stays 0.
//  T2:
//   - Stimulus: D write 0x4000, wdata=128'hDEAD_BEEF repeated.
//   - Required response: l2_write=1, l2_wdata/addr latched; l1_d_wdata changes after grant do not affect l2_wdata; l1_d_resp on l2_resp.
//  T3:
//   - Stimulus: ROUND_ROBIN=0, I read 0x0100 and D read 0x0200 in the same cycle.
//   - Required response: D served first (l2_address=0x0200); then after RECOVER, I served (0x0100) at RECOVER+2.
//  T4:
//   - Stimulus: ROUND_ROBIN=1, both ports held requesting for 4 transactions.
//   - Required response: grant order alternates D,I,D,I (last_served resets to I, so D first).
//  T5:
//   - Stimulus: rst pulsed during SERVE_I, then L2 resp arrives.
//   - Required response: outputs return to reset values next cycle; the stray l2_resp produces no l1_i_resp.
//  T6:
//   - Stimulus: D read and write both high at 0x0800.
//   - Required response: write issued first (l2_write=1, l2_read=0); read served in the following arbitration.

Source files
------------

// File: rtl/l1_mem_arbiter_if.sv
// Bus bundle between the two L1 caches, the L1/L2 arbiter and the L2 port.
// The slave modport is the arbiter's view; master is the surrounding caches/L2 view.
interface l1_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    logic              l1_i_read;
    logic [ADDR_W-1:0] l1_i_address;
    logic [LINE_W-1:0] l1_i_rdata;
    logic              l1_i_resp;

    logic              l1_d_read;
    logic              l1_d_write;
    logic [ADDR_W-1:0] l1_d_address;
    logic [LINE_W-1:0] l1_d_wdata;
    logic [LINE_W-1:0] l1_d_rdata;
    logic              l1_d_resp;

    logic              l2_read;
    logic              l2_write;
    logic [ADDR_W-1:0] l2_address;
    logic [LINE_W-1:0] l2_wdata;
    logic              l2_resp;
    logic [LINE_W-1:0] l2_rdata;

    modport slave (
        input  l1_i_read, l1_i_address,
        input  l1_d_read, l1_d_write, l1_d_address, l1_d_wdata,
        input  l2_resp, l2_rdata,
        output l1_i_rdata, l1_i_resp,
        output l1_d_rdata, l1_d_resp,
        output l2_read, l2_write, l2_address, l2_wdata
    );

    modport master (
        output l1_i_read, l1_i_address,
        output l1_d_read, l1_d_write, l1_d_address, l1_d_wdata,
        output l2_resp, l2_rdata,
        input  l1_i_rdata, l1_i_resp,
        input  l1_d_rdata, l1_d_resp,
        input  l2_read, l2_write, l2_address, l2_wdata
    );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Arbitrates line misses from the L1 I- and D-caches onto the single L2 port,
// one transaction at a time, with registered L2 request/address/data outputs.
module l1_mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 128,
    parameter int ROUND_ROBIN = 0
) (
    input  logic            clk,
    input  logic            rst,
    l1_mem_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SERVE_I = 2'd1;
    localparam logic [1:0] ST_SERVE_D = 2'd2;
    localparam logic [1:0] ST_RECOVER = 2'd3;

    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    logic [1:0]        state_reg, state_next;
    logic              l2_read_reg, l2_read_next;
    logic              l2_write_reg, l2_write_next;
    logic [ADDR_W-1:0] l2_address_reg, l2_address_next;
    logic [LINE_W-1:0] l2_wdata_reg, l2_wdata_next;
    logic              last_served_reg, last_served_next;   // 0: I-cache, 1: D-cache

    logic [1:0]        req;
    logic [ADDR_W-1:0] req_addr [2];
    logic [1:0]        l1_resp;
    logic              tie_to_d;
    logic              grant_d;

    assign req[PORT_I]      = bus.l1_i_read;
    assign req[PORT_D]      = bus.l1_d_read | bus.l1_d_write;
    assign req_addr[PORT_I] = bus.l1_i_address;
    assign req_addr[PORT_D] = bus.l1_d_address;

    // Completion pulses are combinational so each L1 sees resp in the same cycle as L2.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic [1:0] SERVE_ST = (gi == PORT_I) ? ST_SERVE_I : ST_SERVE_D;
            assign l1_resp[gi] = bus.l2_resp & (state_reg == SERVE_ST);
        end

        if (ROUND_ROBIN != 0) begin : g_rr
            assign tie_to_d = ~last_served_reg;
        end else begin : g_fixed
            assign tie_to_d = 1'b1;
        end
    endgenerate

    assign grant_d = req[PORT_D] & (~req[PORT_I] | tie_to_d);

    always_comb begin
        state_next       = state_reg;
        l2_read_next     = l2_read_reg;
        l2_write_next    = l2_write_reg;
        l2_address_next  = l2_address_reg;
        l2_wdata_next    = l2_wdata_reg;
        last_served_next = last_served_reg;

        case (state_reg)
            ST_IDLE: begin
                if (grant_d) begin
                    // A simultaneous D read+write is issued as the writeback; the
                    // read stays asserted and wins a later arbitration.
                    state_next      = ST_SERVE_D;
                    l2_address_next = req_addr[PORT_D];
                    l2_wdata_next   = bus.l1_d_wdata;
                    l2_write_next   = bus.l1_d_write;
                    l2_read_next    = ~bus.l1_d_write;
                end else if (req[PORT_I]) begin
                    state_next      = ST_SERVE_I;
                    l2_address_next = req_addr[PORT_I];
                    l2_read_next    = 1'b1;
                    l2_write_next   = 1'b0;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (bus.l2_resp) begin
                    state_next       = ST_RECOVER;
                    l2_read_next     = 1'b0;
                    l2_write_next    = 1'b0;
                    last_served_next = (state_reg == ST_SERVE_D);
                end
            end
            ST_RECOVER: begin
                // One quiet cycle lets the served L1 drop its level request.
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            l2_read_reg     <= 1'b0;
            l2_write_reg    <= 1'b0;
            l2_address_reg  <= '0;
            l2_wdata_reg    <= '0;
            last_served_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            l2_read_reg     <= l2_read_next;
            l2_write_reg    <= l2_write_next;
            l2_address_reg  <= l2_address_next;
            l2_wdata_reg    <= l2_wdata_next;
            last_served_reg <= last_served_next;
        end
    end

    assign bus.l2_read    = l2_read_reg;
    assign bus.l2_write   = l2_write_reg;
    assign bus.l2_address = l2_address_reg;
    assign bus.l2_wdata   = l2_wdata_reg;

    assign bus.l1_i_resp  = l1_resp[PORT_I];
    assign bus.l1_d_resp  = l1_resp[PORT_D];
    assign bus.l1_i_rdata = bus.l2_rdata;
    assign bus.l1_d_rdata = bus.l2_rdata;
endmodule
